// File: rtl/spram_bus_bridge_pkg.sv
// Shared types and helpers for the SPRAM bus bridge: response entry layout
// and byte-to-word address conversion.
package spram_bus_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef struct packed {
        logic        error;
        logic [31:0] data;
    } rsp_entry_t;

    function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
        return byte_addr / 32'(BYTES_PER_WORD);
    endfunction

endpackage

// File: rtl/spram_bus_bridge_rsp_fifo.sv
// Response FIFO for the SPRAM bus bridge: RSP_DEPTH entries, head presented
// from registered storage, occupancy exported for credit accounting.
module spram_rsp_fifo
    import spram_bus_pkg::*;
#(
    parameter int RSP_DEPTH = 4,
    localparam int CNT_W    = $clog2(RSP_DEPTH + 1),
    localparam int PTR_W    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push_i,
    input  rsp_entry_t       push_entry_i,
    input  logic             pop_i,
    output logic             head_valid_o,
    output rsp_entry_t       head_o,
    output logic [CNT_W-1:0] count_o
);

    rsp_entry_t       mem_q [RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;

    // Pointers wrap modulo RSP_DEPTH so non-power-of-two depths work too.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop       = pop_i && (count_q != '0);
    assign head_valid_o = (count_q != '0);
    assign head_o       = mem_q[rd_ptr_q];
    assign count_o      = count_q;

    always_comb begin
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push_i && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_i && do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

endmodule

// File: rtl/spram_bus_bridge.sv
// Bridge from a valid/ready command/response bus to a single-port SPRAM with
// 1-cycle read latency. Optional address range check: SPRAM_BUS_BRIDGE_RANGE_CHECK_EN.
module spram_bus_bridge
    import spram_bus_pkg::*;
#(
    parameter int WORD_COUNT = 16000,
    parameter int ADDR_WIDTH = 14,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH+1:0] cmd_address,
    input  logic [31:0]           cmd_data,
    input  logic [3:0]            cmd_mask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic                  rsp_error,
    output logic                  ram_en,
    output logic                  ram_wr,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [3:0]            ram_mask,
    output logic [31:0]           ram_wrData,
    input  logic [31:0]           ram_rdData
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

`ifdef SPRAM_BUS_BRIDGE_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   credit_used;
    logic             accept;
    logic             cmd_err;
    logic             pend_valid_q, pend_valid_d;
    logic             pend_write_q, pend_write_d;
    logic             pend_err_q,   pend_err_d;
    rsp_entry_t       push_entry;
    rsp_entry_t       head;
    logic             head_valid;

    // Every in-flight command (pending or queued) holds one FIFO slot, so a
    // push can never find the FIFO full; rsp_ready never reaches cmd_ready.
    assign credit_used = {1'b0, fifo_count} + (CNT_W+1)'(pend_valid_q);
    assign cmd_ready   = resetn && (credit_used < (CNT_W+1)'(RSP_DEPTH));
    assign accept      = cmd_valid && cmd_ready;

    assign cmd_err    = RANGE_CHECK &&
                        (word_index(32'(cmd_address)) >= 32'(WORD_COUNT));
    assign ram_en     = accept && !cmd_err;
    assign ram_wr     = ram_en && cmd_write;
    assign ram_mask   = cmd_write ? cmd_mask : 4'b0;
    assign ram_addr   = ADDR_WIDTH'(word_index(32'(cmd_address)));
    assign ram_wrData = cmd_data;

    always_comb begin
        pend_valid_d = accept;
        pend_write_d = cmd_write;
        pend_err_d   = cmd_err;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_valid_q <= 1'b0;
            pend_write_q <= 1'b0;
            pend_err_q   <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_write_q <= pend_write_d;
            pend_err_q   <= pend_err_d;
        end
    end

    // RAM read data is only valid in the cycle after issue, i.e. while pend is loaded.
    always_comb begin
        push_entry.error = pend_err_q;
        push_entry.data  = (pend_write_q || pend_err_q) ? 32'h0 : ram_rdData;
    end

    spram_rsp_fifo #(
        .RSP_DEPTH (RSP_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .resetn       (resetn),
        .push_i       (pend_valid_q),
        .push_entry_i (push_entry),
        .pop_i        (rsp_valid && rsp_ready),
        .head_valid_o (head_valid),
        .head_o       (head),
        .count_o      (fifo_count)
    );

    assign rsp_valid = head_valid;
    assign rsp_data  = head_valid ? head.data : 32'h0;
    assign rsp_error = head_valid && head.error;

endmodule

// File: tb/tb_spram_bus_bridge.sv
// Self-checking bench for spram_bus_bridge: vector table plus multi-cycle sequences.
module tb_spram_bus_bridge;

    localparam int ADDR_WIDTH = 14;
    localparam int RSP_DEPTH  = 4;
    localparam int WORD_COUNT = 16000;

`ifdef SPRAM_BUS_BRIDGE_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  resetn = 1'b1;
    logic                  cmd_valid = 1'b0;
    logic                  cmd_ready;
    logic                  cmd_write = 1'b0;
    logic [ADDR_WIDTH+1:0] cmd_address = '0;
    logic [31:0]           cmd_data = '0;
    logic [3:0]            cmd_mask = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [31:0]           rsp_data;
    logic                  rsp_error;
    logic                  ram_en;
    logic                  ram_wr;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [3:0]            ram_mask;
    logic [31:0]           ram_wrData;
    logic [31:0]           ram_rdData = '0;

    always #5 clk = ~clk;

    spram_bus_bridge #(
        .WORD_COUNT (WORD_COUNT),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RSP_DEPTH  (RSP_DEPTH)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_address (cmd_address),
        .cmd_data    (cmd_data),
        .cmd_mask    (cmd_mask),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_error   (rsp_error),
        .ram_en      (ram_en),
        .ram_wr      (ram_wr),
        .ram_addr    (ram_addr),
        .ram_mask    (ram_mask),
        .ram_wrData  (ram_wrData),
        .ram_rdData  (ram_rdData)
    );

    // SPRAM model: byte-masked write, 1-cycle read latency.
    logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_mask[b]) mem[ram_addr][8*b +: 8] <= ram_wrData[8*b +: 8];
                end
            end else begin
                ram_rdData <= mem[ram_addr];
            end
        end
    end

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          c;
    } rsp_t;

    int   cyc = 0;
    int   ovf = 0;
    rsp_t rsp_q[$];
    int   acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) acc_q.push_back(cyc);
        if (rsp_valid && rsp_ready) rsp_q.push_back('{rsp_data, rsp_error, cyc});
        if (dut.pend_valid_q && int'(dut.u_fifo.count_o) == RSP_DEPTH) ovf <= ovf + 1;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int n, input string nm);
        int k;
        k = 0;
        while (rsp_q.size() < n && k < 60) begin
            tick();
            k++;
        end
        check({nm, "_rsp_count"}, 32'(rsp_q.size()), 32'(n));
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic        exp_en;
        logic [13:0] exp_ra;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vt[10];

    initial begin
        int idx;
        int k;

        for (int i = 0; i < (1 << ADDR_WIDTH); i++) mem[i] = 32'h0;
        for (int i = 0; i < 16; i++) mem[32'h40 + i] = 32'hA500_0000 + 32'(i);

        vt[0] = '{1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 1'b1, 14'd4,      32'h0,        1'b0};
        vt[1] = '{1'b0, 16'h0010, 32'h0,        4'hF, 1'b1, 14'd4,      32'hDEADBEEF, 1'b0};
        vt[2] = '{1'b1, 16'h0020, 32'h11223344, 4'hF, 1'b1, 14'd8,      32'h0,        1'b0};
        vt[3] = '{1'b1, 16'h0020, 32'hAABBCCDD, 4'h5, 1'b1, 14'd8,      32'h0,        1'b0};
        vt[4] = '{1'b0, 16'h0020, 32'h0,        4'h0, 1'b1, 14'd8,      32'h11BB33DD, 1'b0};
        vt[5] = '{1'b0, 16'h0013, 32'h0,        4'h0, 1'b1, 14'd4,      32'hDEADBEEF, 1'b0};
        vt[6] = '{1'b1, 16'hF9FC, 32'hCAFEF00D, 4'hF, 1'b1, 14'h3E7F,   32'h0,        1'b0};
        vt[7] = '{1'b0, 16'hF9FC, 32'h0,        4'h0, 1'b1, 14'h3E7F,   32'hCAFEF00D, 1'b0};
        vt[8] = '{1'b1, 16'hFA00, 32'h12345678, 4'hF, !RC,  14'h3E80,   32'h0,        RC};
        vt[9] = '{1'b0, 16'hFA00, 32'h0,        4'h0, !RC,  14'h3E80,
                  RC ? 32'h0 : 32'h12345678, RC};

        // Reset state, with a command presented while reset is held
        #1 resetn = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_address = 16'h0010;
        rsp_ready = 1'b1;
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_data",  rsp_data,       32'h0);
        check("rst_rsp_error", 32'(rsp_error), 32'h0);
        check("rst_ram_en",    32'(ram_en),    32'h0);
        check("rst_ram_wr",    32'(ram_wr),    32'h0);
        tick();
        tick();
        cmd_valid = 1'b0;
        resetn = 1'b1;
        tick();

        // Vector table: one transaction at a time
        for (int i = 0; i < 10; i++) begin
            rsp_q.delete();
            rsp_ready   = 1'b1;
            cmd_valid   = 1'b1;
            cmd_write   = vt[i].wr;
            cmd_address = vt[i].addr;
            cmd_data    = vt[i].data;
            cmd_mask    = vt[i].mask;
            #1;
            check($sformatf("v%0d_cmd_ready", i), 32'(cmd_ready), 32'h1);
            check($sformatf("v%0d_ram_en", i),    32'(ram_en),    32'(vt[i].exp_en));
            check($sformatf("v%0d_ram_wr", i),    32'(ram_wr),    32'(vt[i].exp_en & vt[i].wr));
            check($sformatf("v%0d_ram_addr", i),  32'(ram_addr),  32'(vt[i].exp_ra));
            check($sformatf("v%0d_ram_mask", i),  32'(ram_mask),  vt[i].wr ? 32'(vt[i].mask) : 32'h0);
            if (vt[i].wr) check($sformatf("v%0d_ram_wrData", i), ram_wrData, vt[i].data);
            tick();
            cmd_valid = 1'b0;
            wait_rsp(1, $sformatf("v%0d", i));
            if (rsp_q.size() > 0) begin
                check($sformatf("v%0d_rsp_data", i), rsp_q[0].data,       vt[i].exp_rd);
                check($sformatf("v%0d_rsp_err", i),  32'(rsp_q[0].err),   32'(vt[i].exp_err));
            end
        end

        // Back-to-back write then read, same address
        rsp_q.delete();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 16'h0040;
        cmd_data = 32'h55667788; cmd_mask = 4'hF;
        tick();
        cmd_write = 1'b0;
        tick();
        cmd_valid = 1'b0;
        wait_rsp(2, "b2b");
        if (rsp_q.size() >= 2) begin
            check("b2b_wr_data", rsp_q[0].data, 32'h0);
            check("b2b_rd_data", rsp_q[1].data, 32'h55667788);
        end

        // Backpressure: 8 reads with rsp_ready low
        rsp_q.delete();
        rsp_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            cmd_valid = 1'b1; cmd_write = 1'b0;
            cmd_address = 16'(32'h100 + 4 * idx);
            #1;
            if (cmd_ready) idx++;
            tick();
        end
        #1;
        check("bp_accepted",  32'(idx),          32'(RSP_DEPTH));
        check("bp_cmd_ready", 32'(cmd_ready),    32'h0);
        check("bp_rsp_valid", 32'(rsp_valid),    32'h1);
        check("bp_no_rsp",    32'(rsp_q.size()), 32'h0);
        rsp_ready = 1'b1;
        tick();
        k = 0;
        while (idx < 8 && k < 40) begin
            cmd_valid = 1'b1;
            cmd_address = 16'(32'h100 + 4 * idx);
            #1;
            if (cmd_ready) idx++;
            tick();
            k++;
        end
        cmd_valid = 1'b0;
        check("bp_all_accepted", 32'(idx), 32'h8);
        wait_rsp(8, "bp");
        for (int c = 0; c < 4; c++) tick();
        check("bp_no_dup", 32'(rsp_q.size()), 32'h8);
        for (int i = 0; i < 8 && i < rsp_q.size(); i++)
            check($sformatf("bp_rsp%0d", i), rsp_q[i].data, 32'hA500_0000 + 32'(i));

        // Streaming: 16 reads with rsp_ready high
        rsp_q.delete();
        acc_q.delete();
        for (int i = 0; i < 16; i++) begin
            cmd_valid = 1'b1; cmd_write = 1'b0;
            cmd_address = 16'(32'h100 + 4 * i);
            tick();
        end
        cmd_valid = 1'b0;
        check("st_accepts", 32'(acc_q.size()), 32'd16);
        wait_rsp(16, "st");
        if (acc_q.size() == 16 && rsp_q.size() == 16) begin
            check("st_accept_span",  32'(acc_q[15] - acc_q[0]), 32'd15);
            check("st_first_latency", 32'(rsp_q[0].c - acc_q[0]), 32'd2);
            for (int i = 0; i < 16; i++)
                check($sformatf("st_rsp%0d", i), rsp_q[i].data, 32'hA500_0000 + 32'(i));
        end

        // Reset mid-stream with reads in flight
        rsp_q.delete();
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_write = 1'b0;
            cmd_address = 16'(32'h100 + 4 * i);
            tick();
        end
        resetn = 1'b0;
        cmd_address = 16'h010C;
        #1;
        check("mrst_cmd_ready", 32'(cmd_ready), 32'h0);
        check("mrst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("mrst_ram_en",    32'(ram_en),    32'h0);
        tick();
        resetn = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        #1;
        check("mrst_no_stale",   32'(rsp_q.size()), 32'h0);
        check("mrst_rsp_valid2", 32'(rsp_valid),    32'h0);
        tick();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 16'h0104;
        tick();
        cmd_valid = 1'b0;
        wait_rsp(1, "mrst_after");
        if (rsp_q.size() > 0) check("mrst_after_data", rsp_q[0].data, 32'hA500_0001);

        check("fifo_no_overflow", 32'(ovf), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spram_bus_bridge.md
Name: spram_bus_bridge

Overview:
Initiator-side bridge that turns a valid/ready command/response bus into accesses on a single-port 1-write-or-read SPRAM macro port. The SPRAM port has en/wr/addr/mask/wrData signals and a fixed 1-cycle read latency. The bridge issues at most one RAM access per cycle and captures read data exactly one cycle after issue. It buffers responses in a small FIFO so that the bus may backpressure without losing RAM data. It sits between the CPU/DMA memory bus and the SPRAM wrapper.

Parameters:
WORD_COUNT, 16000, number of implemented 32-bit words; addresses at or above it are out of range.
ADDR_WIDTH, 14, RAM word-address width.
RSP_DEPTH, 4, response FIFO entries; minimum 2.

Ports:
clk  in  1  single clock.
resetn  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
cmd_write  in  1  1 = write, 0 = read.
cmd_address  in  ADDR_WIDTH+2  byte address; bits [1:0] ignored.
cmd_data  in  32  write data.
cmd_mask  in  4  byte enables; bit n covers data[8n+7:8n].
rsp_valid  out  1  response present.
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
rsp_data  out  32  read data; 0 for writes.
rsp_error  out  1  access error (see Optional Feature).
ram_en  out  1  RAM enable.
ram_wr  out  1  RAM write strobe.
ram_addr  out  ADDR_WIDTH  word address = cmd_address[ADDR_WIDTH+1:2].
ram_mask  out  4  byte write mask.
ram_wrData  out  32  RAM write data.
ram_rdData  in  32  RAM read data, valid the cycle after a read issue.

Behaviour:
- Reset values (asynchronous, resetn low): cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_error=0, ram_en=0, ram_wr=0, FIFO empty, pending stage empty.
- cmd_ready=1 iff resetn is high and (fifo_count + pend_valid) < RSP_DEPTH.
- cmd_ready depends only on registered state. There is no combinational path from rsp_ready to cmd_ready.
- The command path is combinational to the RAM on the accept cycle:
  - ram_en = cmd_valid && cmd_ready.
  - ram_wr = ram_en && cmd_write.
  - ram_mask = cmd_write ? cmd_mask : 4'b0.
  - ram_addr and ram_wrData follow cmd_address and cmd_data.
- Accept cycle N: a pend register stage loads pend_valid=1, pend_write and pend_err.
- Cycle N+1: the pend stage pushes one entry into the FIFO.
  - Read entry: data = ram_rdData sampled in cycle N+1, error = pend_err.
  - Write entry: data = 0, error = pend_err.
- Every accepted command yields exactly one response, in order.
- Minimum latency is 2 cycles from cmd accept to rsp_valid, since responses come from the FIFO head register.
- With rsp_ready held high and cmd_valid held high, throughput is 1 command/cycle.
- Push and pop in the same cycle: count is unchanged. Pushing while full cannot occur because credit accounting guarantees room; the bench asserts this.
- Pointer wrap: read/write pointers wrap modulo RSP_DEPTH. The count register is $clog2(RSP_DEPTH+1) bits wide.
- Back-to-back write then read to the same address returns the newly written bytes (RAM ordering is preserved because issue order equals cycle order).
- Reset asserted mid-operation drops the pend stage and all FIFO contents immediately, and no RAM access is issued while resetn is low. A read in flight is discarded.

Optional Feature:
Macro SPRAM_BUS_BRIDGE_RANGE_CHECK_EN.
- Defined:
  - A command with word address >= WORD_COUNT is still accepted under the same credit rule.
  - ram_en is held 0 for that command, so no RAM access is issued.
  - Its response carries rsp_error=1 and rsp_data=0.
- Undefined:
  - No range check; ram_addr passes through unchanged.
  - Out-of-range behaviour is that of the RAM macro.
  - rsp_error is tied 0.

Decomposition:
- Package spram_bus_pkg holds:
  - a typedef for the response entry {error, data[31:0]};
  - the constant BYTES_PER_WORD=4;
  - a function computing the word index from a byte address.
- One sub-module, spram_rsp_fifo: a synchronous RSP_DEPTH-entry FIFO with registered head, count output, and push/pop ports.
- The credit logic, pend stage and RAM drive stay in the top.

Test Plan:
- Write 0xDEADBEEF to byte address 0x0010 with mask 4'hF, then read 0x0010 -> ram_addr=4; read rsp_data=0xDEADBEEF, rsp_error=0; two responses in order.
- Write 0x11223344 (mask F), then write 0xAABBCCDD with mask 4'b0101, then read -> rsp_data=0x11BB33DD.
- Stream 8 reads with rsp_ready held low -> exactly RSP_DEPTH (4) accepted, then cmd_ready=0. Raise rsp_ready -> all 8 responses returned in order, with no loss or duplication.
- Stream 16 reads with rsp_ready=1 -> one accept per cycle, and first rsp_valid 2 cycles after the first accept.
- Accept 3 reads, then pull resetn low for 1 cycle mid-stream -> rsp_valid=0 and cmd_ready=0 during reset. After release, the FIFO is empty and no stale response appears.
- With SPRAM_BUS_BRIDGE_RANGE_CHECK_EN, read byte address 0xFA00 (word 16000) -> ram_en stays 0, rsp_error=1, rsp_data=0. Without the macro -> ram_en=1 and rsp_error=0.
